// File: rtl/grn_out_arbiter.sv
// grn_out_arbiter: round-robin arbiter that shares one output-FIFO packer between
// NUM_REQ accelerator output streams. Each grant is a burst of BURST words, so that
// every packed output line comes from a single source. A burst that ends early on
// req_last is topped up with zero pad words to keep packer lines aligned.
module grn_out_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 256,
  parameter int BURST   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifoout_almostfull,
  output logic                      out_wr_en,
  output logic [DATA_W-1:0]         out_wr_data,
  output logic                      out_pad,
  output logic [31:0]               task_done,
  output logic [4:0]                grant_idx,
  output logic                      all_done
);

  // Beat counter must be able to hold the value BURST itself (end of a padded burst).
  localparam int               BCW        = $clog2(BURST) + 1;
  localparam logic [BCW-1:0]   BURST_LEN  = BCW'(BURST);
  localparam logic [BCW-1:0]   BURST_LAST = BCW'(BURST - 1);
  localparam logic [4:0]       LAST_REQ   = 5'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_BURST,
    S_PAD,
    S_DONE
  } state_t;

  // Control registers
  state_t               r_state;
  logic [4:0]           r_rr_ptr;
  logic [BCW-1:0]       r_beat_cnt;
  logic [NUM_REQ-1:0]   r_done_mask;
  logic [4:0]           r_grant_idx;
  logic                 r_all_done;

  // Output stage registers (word to the packer travels with its strobe)
  logic                 r_vld_p1;
  logic [DATA_W-1:0]    r_data_p1;
  logic                 r_pad_p1;

  // Next-state values
  state_t               w_state_nxt;
  logic [4:0]           w_rr_ptr_nxt;
  logic [BCW-1:0]       w_beat_cnt_nxt;
  logic [NUM_REQ-1:0]   w_done_mask_nxt;
  logic [4:0]           w_grant_idx_nxt;
  logic                 w_all_done_nxt;
  logic                 w_vld_nxt;
  logic [DATA_W-1:0]    w_data_nxt;
  logic                 w_pad_nxt;

  // Datapath / decode wires
  logic [NUM_REQ-1:0]   w_gnt_oh;
  logic [NUM_REQ-1:0]   w_elig;
  logic                 w_arb_found;
  logic [4:0]           w_arb_idx;
  logic                 w_burst_go;
  logic                 w_cur_valid;
  logic                 w_cur_last;
  logic [DATA_W-1:0]    w_cur_data;
  logic                 w_xfer;
  logic [BCW-1:0]       w_beat_inc;
  logic [4:0]           w_rr_adv;
  logic [31:0]          w_task_done;

  // Decode the current grant into a one-hot mask so requester vectors are
  // indexed only by constants.
  always_comb begin
    w_gnt_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_oh[i] = (r_grant_idx == 5'(i));
    end
  end

  // Select the granted requester's word.
  always_comb begin
    w_cur_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_oh[i]) begin
        w_cur_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin scan: the eligible requester at the smallest distance above
  // rr_ptr (with wrap) wins; done requesters are never eligible.
  always_comb begin : arb_scan
    int d;
    int best_d;
    d           = 0;
    best_d      = NUM_REQ;
    w_arb_idx   = '0;
    w_elig      = req_valid & ~r_done_mask;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(r_rr_ptr);
      if (d < 0) begin
        d = d + NUM_REQ;
      end
      if (w_elig[i] && (d < best_d)) begin
        best_d    = d;
        w_arb_idx = 5'(i);
      end
    end
    w_arb_found = (best_d < NUM_REQ);
  end

  assign w_burst_go  = (r_state == S_BURST) && start && !fifoout_almostfull;
  assign req_ready   = w_gnt_oh & {NUM_REQ{w_burst_go}};
  assign w_cur_valid = |(req_valid & w_gnt_oh);
  assign w_cur_last  = |(req_last & w_gnt_oh);
  assign w_xfer      = w_burst_go && w_cur_valid;
  assign w_beat_inc  = r_beat_cnt + 1'b1;
  assign w_rr_adv    = (r_grant_idx == LAST_REQ) ? 5'd0 : (r_grant_idx + 5'd1);

  // Report per-requester completion; unused upper bits read as finished.
  always_comb begin
    w_task_done                = '1;
    w_task_done[NUM_REQ-1:0]   = r_done_mask;
  end

  // Next-state and output-stage decode; start low holds everything outside IDLE/DONE.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_done_mask_nxt = r_done_mask;
    w_grant_idx_nxt = r_grant_idx;
    w_all_done_nxt  = r_all_done;
    w_vld_nxt       = 1'b0;
    w_data_nxt      = r_data_p1;
    w_pad_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARB;
        end
      end
      S_ARB: begin
        if (start) begin
          if (&r_done_mask) begin
            w_state_nxt = S_DONE;
          end else if (!fifoout_almostfull && w_arb_found) begin
            w_grant_idx_nxt = w_arb_idx;
            w_beat_cnt_nxt  = '0;
            w_state_nxt     = S_BURST;
          end
        end
      end
      S_BURST: begin
        if (w_xfer) begin
          w_beat_cnt_nxt = w_beat_inc;
          w_vld_nxt      = 1'b1;
          w_data_nxt     = w_cur_data;
          if (w_cur_last) begin
            w_done_mask_nxt = r_done_mask | w_gnt_oh;
            w_rr_ptr_nxt    = w_rr_adv;
            w_state_nxt     = (w_beat_inc < BURST_LEN) ? S_PAD : S_ARB;
          end else if (r_beat_cnt == BURST_LAST) begin
            w_rr_ptr_nxt = w_rr_adv;
            w_state_nxt  = S_ARB;
          end
        end
      end
      S_PAD: begin
        if (start && !fifoout_almostfull) begin
          w_beat_cnt_nxt = w_beat_inc;
          w_vld_nxt      = 1'b1;
          w_data_nxt     = '0;
          w_pad_nxt      = 1'b1;
          if (w_beat_inc == BURST_LEN) begin
            w_state_nxt = S_ARB;
          end
        end
      end
      S_DONE: begin
        w_all_done_nxt = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration bookkeeping and the registered packer interface.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_done_mask <= '0;
      r_grant_idx <= '0;
      r_all_done  <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_data_p1   <= '0;
      r_pad_p1    <= 1'b0;
    end else begin
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_done_mask <= w_done_mask_nxt;
      r_grant_idx <= w_grant_idx_nxt;
      r_all_done  <= w_all_done_nxt;
      r_vld_p1    <= w_vld_nxt;
      r_data_p1   <= w_data_nxt;
      r_pad_p1    <= w_pad_nxt;
    end
  end

  assign out_wr_en   = r_vld_p1;
  assign out_wr_data = r_data_p1;
  assign out_pad     = r_pad_p1;
  assign task_done   = w_task_done;
  assign grant_idx   = r_grant_idx;
  assign all_done    = r_all_done;

endmodule
